// File: rtl/sram_axi4_slave.sv
// sram_axi4_slave: byte-addressed SRAM behind an AXI4 slave port with independent read/write FSMs and FIXED/INCR/WRAP bursts
module sram_axi4_slave #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4,
    parameter int USER_WIDTH = 4
) (
    input  logic                    i_aclk,
    input  logic                    i_areset,
    input  logic [ID_WIDTH-1:0]     i_arid,
    input  logic [ADDR_WIDTH-1:0]   i_araddr,
    input  logic [7:0]              i_arlen,
    input  logic [2:0]              i_arsize,
    input  logic [1:0]              i_arburst,
    input  logic [1:0]              i_arlock,
    input  logic [3:0]              i_arcache,
    input  logic [2:0]              i_arprot,
    input  logic [3:0]              i_arqos,
    input  logic [3:0]              i_arregion,
    input  logic [USER_WIDTH-1:0]   i_aruser,
    input  logic                    i_arvalid,
    output logic                    o_arready,
    output logic [ID_WIDTH-1:0]     o_rid,
    output logic [DATA_WIDTH-1:0]   o_rdata,
    output logic [1:0]              o_rresp,
    output logic                    o_rlast,
    output logic [USER_WIDTH-1:0]   o_ruser,
    output logic                    o_rvalid,
    input  logic                    i_rready,
    input  logic [ID_WIDTH-1:0]     i_awid,
    input  logic [ADDR_WIDTH-1:0]   i_awaddr,
    input  logic [7:0]              i_awlen,
    input  logic [2:0]              i_awsize,
    input  logic [1:0]              i_awburst,
    input  logic [1:0]              i_awlock,
    input  logic [3:0]              i_awcache,
    input  logic [2:0]              i_awprot,
    input  logic [3:0]              i_awqos,
    input  logic [3:0]              i_awregion,
    input  logic [USER_WIDTH-1:0]   i_awuser,
    input  logic                    i_awvalid,
    output logic                    o_awready,
    input  logic [ID_WIDTH-1:0]     i_wid,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_wstrb,
    input  logic                    i_wlast,
    input  logic [USER_WIDTH-1:0]   i_wuser,
    input  logic                    i_wvalid,
    output logic                    o_wready,
    output logic [ID_WIDTH-1:0]     o_bid,
    output logic [1:0]              o_bresp,
    output logic [USER_WIDTH-1:0]   o_buser,
    output logic                    o_bvalid,
    input  logic                    i_bready
);
    localparam int STRB  = DATA_WIDTH / 8;
    localparam int LB    = $clog2(STRB);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {R_IDLE, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

    logic [7:0] mem [DEPTH];

    r_state_t r_state, r_next;
    logic [ID_WIDTH-1:0] r_id;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [7:0] r_len, r_cnt;
    logic [2:0] r_size;
    logic [1:0] r_burst;
    logic [DATA_WIDTH-1:0] r_word;

    w_state_t w_state, w_next;
    logic [ID_WIDTH-1:0] w_id;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [7:0] w_len, w_cnt;
    logic [2:0] w_size;
    logic [1:0] w_burst;

    logic unused_ok;
    assign unused_ok = ^{i_wid, i_arlock, i_awlock, i_arcache, i_awcache, i_arprot, i_awprot, i_arqos,
                         i_awqos, i_arregion, i_awregion, i_aruser, i_awuser, i_wuser, i_wlast};

    // WRAP with a length other than 2/4/8/16 beats degrades to INCR
    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a, input logic [7:0] len,
                                                        input logic [2:0] size, input logic [1:0] burst);
        logic [31:0] bound, sum;
        logic wrap;
        bound = (32'(len) + 32'd1) << size;
        sum = 32'(a) + (32'd1 << size);
        wrap = burst == 2'b10 && (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
        next_addr = burst == 2'b00 ? a
                  : wrap ? ADDR_WIDTH'((32'(a) & ~(bound - 32'd1)) | (sum & (bound - 32'd1)))
                  : ADDR_WIDTH'(sum);
    endfunction

    always_comb begin
        o_arready = r_state == R_IDLE;
        o_rvalid = r_state == R_DATA;
        r_next = r_state == R_IDLE ? (i_arvalid ? R_DATA : R_IDLE)
               : (i_rready && r_cnt == r_len ? R_IDLE : R_DATA);
    end

    always_comb begin
        r_word = '0;
        for (int l = 0; l < STRB; l++)
            r_word[8*l +: 8] = mem[{r_addr[ADDR_WIDTH-1:LB], LB'(l)}];
    end

    assign o_rdata = o_rvalid ? r_word : '0;
    assign o_rlast = o_rvalid && r_cnt == r_len;
    assign o_rid = r_id;
    assign o_rresp = 2'b00;
    assign o_ruser = '0;

    always_ff @(posedge i_aclk or posedge i_areset) begin
        if (i_areset) begin
            r_state <= R_IDLE;
            r_id <= '0;
            r_addr <= '0;
            r_len <= '0;
            r_cnt <= '0;
            r_size <= '0;
            r_burst <= '0;
        end else begin
            r_state <= r_next;
            if (r_state == R_IDLE && i_arvalid) begin
                r_id <= i_arid;
                r_addr <= i_araddr;
                r_len <= i_arlen;
                r_size <= i_arsize;
                r_burst <= i_arburst;
                r_cnt <= '0;
            end else if (r_state == R_DATA && i_rready) begin
                r_cnt <= r_cnt + 8'd1;
                r_addr <= next_addr(r_addr, r_len, r_size, r_burst);
            end
        end
    end

    always_comb begin
        o_awready = w_state == W_IDLE;
        o_wready = w_state == W_DATA;
        o_bvalid = w_state == W_RESP;
        w_next = w_state == W_IDLE ? (i_awvalid ? W_DATA : W_IDLE)
               : w_state == W_DATA ? (i_wvalid && w_cnt == w_len ? W_RESP : W_DATA)
               : (i_bready ? W_IDLE : W_RESP);
    end

    assign o_bid = w_id;
    assign o_bresp = 2'b00;
    assign o_buser = '0;

    always_ff @(posedge i_aclk or posedge i_areset) begin
        if (i_areset) begin
            w_state <= W_IDLE;
            w_id <= '0;
            w_addr <= '0;
            w_len <= '0;
            w_cnt <= '0;
            w_size <= '0;
            w_burst <= '0;
        end else begin
            w_state <= w_next;
            if (w_state == W_IDLE && i_awvalid) begin
                w_id <= i_awid;
                w_addr <= i_awaddr;
                w_len <= i_awlen;
                w_size <= i_awsize;
                w_burst <= i_awburst;
                w_cnt <= '0;
            end else if (w_state == W_DATA && i_wvalid) begin
                w_cnt <= w_cnt + 8'd1;
                w_addr <= next_addr(w_addr, w_len, w_size, w_burst);
            end
        end
    end

    // reset reloads each byte with its own address so contents are predictable
    always_ff @(posedge i_aclk or posedge i_areset) begin
        if (i_areset) begin
            for (int k = 0; k < DEPTH; k++)
                mem[k] <= 8'(k);
        end else if (w_state == W_DATA && i_wvalid) begin
            for (int l = 0; l < STRB; l++)
                if (i_wstrb[l])
                    mem[{w_addr[ADDR_WIDTH-1:LB], LB'(l)}] <= i_wdata[8*l +: 8];
        end
    end
endmodule

// File: tb/tb_sram_axi4_slave.sv
// tb_sram_axi4_slave: directed and random bursts checked against a byte-array memory model
module tb_sram_axi4_slave;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic [3:0] arid, awid, rid, bid;
    logic [7:0] araddr, awaddr, arlen, awlen;
    logic [2:0] arsize, awsize;
    logic [1:0] arburst, awburst, rresp, bresp;
    logic arvalid, arready, rvalid, rready, rlast;
    logic awvalid, awready, wvalid, wready, bvalid, bready;
    logic [63:0] rdata, wdata;
    logic [7:0] wstrb;
    logic [3:0] ruser, buser;

    sram_axi4_slave dut (
        .i_aclk(clk), .i_areset(rst),
        .i_arid(arid), .i_araddr(araddr), .i_arlen(arlen), .i_arsize(arsize), .i_arburst(arburst),
        .i_arlock(2'b00), .i_arcache(4'h0), .i_arprot(3'b000), .i_arqos(4'h0), .i_arregion(4'h0),
        .i_aruser(4'h0), .i_arvalid(arvalid), .o_arready(arready),
        .o_rid(rid), .o_rdata(rdata), .o_rresp(rresp), .o_rlast(rlast), .o_ruser(ruser),
        .o_rvalid(rvalid), .i_rready(rready),
        .i_awid(awid), .i_awaddr(awaddr), .i_awlen(awlen), .i_awsize(awsize), .i_awburst(awburst),
        .i_awlock(2'b00), .i_awcache(4'h0), .i_awprot(3'b000), .i_awqos(4'h0), .i_awregion(4'h0),
        .i_awuser(4'h0), .i_awvalid(awvalid), .o_awready(awready),
        .i_wid(4'h0), .i_wdata(wdata), .i_wstrb(wstrb), .i_wlast(1'b0), .i_wuser(4'h0),
        .i_wvalid(wvalid), .o_wready(wready),
        .o_bid(bid), .o_bresp(bresp), .o_buser(buser), .o_bvalid(bvalid), .i_bready(bready)
    );

    int total = 0, bad = 0;
    logic [7:0] ref_mem [256];
    logic [63:0] rbuf [256];
    logic [63:0] wdat [256];
    logic [7:0] wstb [256];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] beat_addr(input int start, input int len, input int size, input int burst, input int i);
        int step, bound;
        step = 1 << size;
        bound = (len + 1) * step;
        if (burst == 0) return 8'(start);
        if (burst == 2 && (len == 1 || len == 3 || len == 7 || len == 15))
            return 8'((start / bound) * bound + (start % bound + i * step) % bound);
        return 8'(start + i * step);
    endfunction

    function automatic logic [63:0] ref_word(input logic [7:0] a);
        logic [63:0] w;
        for (int l = 0; l < 8; l++) w[8*l +: 8] = ref_mem[int'(a & 8'hF8) + l];
        return w;
    endfunction

    task automatic reset_model();
        for (int k = 0; k < 256; k++) ref_mem[k] = 8'(k);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_arready", 64'(arready), 64'd1);
        chk("rst_awready", 64'(awready), 64'd1);
        chk("rst_rvalid", 64'(rvalid), 64'd0);
        chk("rst_rdata", rdata, 64'd0);
        chk("rst_rlast_rid_rresp_ruser", 64'({rlast, rid, rresp, ruser}), 64'd0);
        chk("rst_wready", 64'(wready), 64'd0);
        chk("rst_bvalid_bid_bresp_buser", 64'({bvalid, bid, bresp, buser}), 64'd0);
    endtask

    task automatic do_read(input int addr, input int len, input int size, input int burst, input int id, input int stall);
        int n;
        logic [63:0] exp;
        @(negedge clk);
        arvalid = 1'b1; araddr = 8'(addr); arlen = 8'(len); arsize = 3'(size); arburst = 2'(burst); arid = 4'(id);
        n = 0;
        while (!arready && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) chk("ar_timeout", 64'd0, 64'd1);
        @(negedge clk);
        arvalid = 1'b0;
        chk("r_latency", 64'(rvalid), 64'd1);
        chk("arready_busy", 64'(arready), 64'd0);
        for (int i = 0; i <= len; i++) begin
            exp = ref_word(beat_addr(addr, len, size, burst, i));
            if (i == stall) begin
                rready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    chk("r_stall_valid", 64'(rvalid), 64'd1);
                    chk("r_stall_data", rdata, exp);
                    chk("r_stall_last", 64'(rlast), 64'(i == len));
                    @(negedge clk);
                end
            end
            rready = 1'b1;
            chk("rvalid", 64'(rvalid), 64'd1);
            chk("rdata", rdata, exp);
            chk("rlast", 64'(rlast), 64'(i == len));
            chk("rid", 64'(rid), 64'(id));
            chk("rresp", 64'(rresp), 64'd0);
            rbuf[i] = rdata;
            @(negedge clk);
            rready = 1'b0;
        end
        chk("r_done", 64'(rvalid), 64'd0);
        chk("arready_back", 64'(arready), 64'd1);
    endtask

    task automatic do_write(input int addr, input int len, input int size, input int burst, input int id, input int bstall);
        int n;
        logic [7:0] a;
        @(negedge clk);
        chk("w_idle_wready", 64'(wready), 64'd0);
        awvalid = 1'b1; awaddr = 8'(addr); awlen = 8'(len); awsize = 3'(size); awburst = 2'(burst); awid = 4'(id);
        n = 0;
        while (!awready && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) chk("aw_timeout", 64'd0, 64'd1);
        @(negedge clk);
        awvalid = 1'b0;
        chk("awready_busy", 64'(awready), 64'd0);
        for (int i = 0; i <= len; i++) begin
            if ($urandom % 4 == 0) begin wvalid = 1'b0; @(negedge clk); end
            wvalid = 1'b1; wdata = wdat[i]; wstrb = wstb[i];
            chk("wready", 64'(wready), 64'd1);
            a = beat_addr(addr, len, size, burst, i);
            for (int l = 0; l < 8; l++)
                if (wstb[i][l]) ref_mem[int'(a & 8'hF8) + l] = wdat[i][8*l +: 8];
            @(negedge clk);
        end
        wvalid = 1'b0;
        chk("bvalid", 64'(bvalid), 64'd1);
        chk("bid", 64'(bid), 64'(id));
        chk("bresp", 64'(bresp), 64'd0);
        chk("wready_resp", 64'(wready), 64'd0);
        for (int s = 0; s < bstall; s++) begin
            @(negedge clk);
            chk("b_held", 64'(bvalid), 64'd1);
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        chk("b_done", 64'(bvalid), 64'd0);
        chk("awready_back", 64'(awready), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int len, size, burst, addr;
        rst = 1'b0;
        arvalid = 1'b0; rready = 1'b0; awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; wdata = '0; wstrb = '0;
        #1 rst = 1'b1;
        #10 chk_reset_outputs();
        @(negedge clk);
        rst = 1'b0;
        reset_model();

        do_read(8'h08, 0, 3, 1, 1, -1);
        chk("tp_single", rbuf[0], 64'h0F0E0D0C0B0A0908);

        do_read(8'h10, 1, 3, 0, 2, -1);
        chk("tp_fixed0", rbuf[0], 64'h1716151413121110);
        chk("tp_fixed1", rbuf[1], 64'h1716151413121110);

        do_read(8'h18, 3, 3, 2, 4, -1);
        chk("tp_wrap0", rbuf[0], 64'h1F1E1D1C1B1A1918);
        chk("tp_wrap1", rbuf[1], 64'h0706050403020100);
        chk("tp_wrap2", rbuf[2], 64'h0F0E0D0C0B0A0908);
        chk("tp_wrap3", rbuf[3], 64'h1716151413121110);

        wdat[0] = '1; wstb[0] = 8'h0F;
        do_write(8'h20, 0, 3, 1, 5, 3);
        do_read(8'h20, 0, 3, 1, 0, -1);
        chk("tp_strobe", rbuf[0], 64'h27262524FFFFFFFF);

        for (int i = 0; i < 9; i++) begin wdat[i] = 64'h1111_0000_0000_0000 + 64'(i); wstb[i] = 8'hFF; end
        do_write(8'h00, 8, 3, 1, 1, 2);
        do_read(8'h00, 8, 3, 1, 3, 4);
        for (int i = 0; i < 9; i++) chk("tp_incr9", rbuf[i], 64'h1111_0000_0000_0000 + 64'(i));

        for (int t = 0; t < 12; t++) begin
            addr = int'($urandom_range(0, 255));
            len = int'($urandom_range(0, 7));
            size = int'($urandom_range(0, 3));
            burst = int'($urandom_range(0, 3));
            for (int i = 0; i <= len; i++) begin wdat[i] = {$urandom, $urandom}; wstb[i] = 8'($urandom); end
            do_write(addr, len, size, burst, int'($urandom_range(0, 15)), int'($urandom_range(0, 2)));
            do_read(addr, len, size, burst, int'($urandom_range(0, 15)), int'($urandom_range(0, 8)));
            do_read(int'($urandom_range(0, 255)), int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), 6, -1);
        end

        @(negedge clk);
        awvalid = 1'b1; awaddr = 8'h40; awlen = 8'd3; awsize = 3'd3; awburst = 2'b01; awid = 4'd9;
        @(negedge clk);
        awvalid = 1'b0;
        wvalid = 1'b1; wdata = 64'hDEAD_BEEF_CAFE_F00D; wstrb = 8'hFF;
        @(negedge clk);
        wdata = 64'h0123_4567_89AB_CDEF;
        #2 rst = 1'b1;
        #1 chk_reset_outputs();
        @(negedge clk);
        wvalid = 1'b0;
        rst = 1'b0;
        reset_model();
        do_read(8'h00, 31, 3, 1, 7, 10);
        chk("rst_reload_40", rbuf[8], 64'h4746454443424140);
        chk("rst_reload_48", rbuf[9], 64'h4F4E4D4C4B4A4948);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sram_axi4_slave.md
Name: sram_axi4_slave

Overview:
- Byte-addressed 256-byte on-chip SRAM behind an AXI4 slave port with a 64-bit data bus.
- Independent read (AR/R) and write (AW/W/B) state machines; supports FIXED, INCR and WRAP bursts.
- Used as a simple memory target for AXI4 masters in subsystem testbenches and SoC integration.

Parameters:
- ADDR_WIDTH, 8: byte address width; memory depth is 2^ADDR_WIDTH bytes.
- DATA_WIDTH, 64: data bus width; strobe width is DATA_WIDTH/8.
- ID_WIDTH, 4: AXI ID width.
- USER_WIDTH, 4: AXI user sideband width.

Ports:
- i_aclk  in  1  clock; all logic is on the rising edge.
- i_areset  in  1  reset; asynchronous, active-high.
- i_arid / i_awid / i_wid  in  ID_WIDTH  transaction IDs; i_wid is ignored.
- i_araddr / i_awaddr  in  ADDR_WIDTH  start byte address.
- i_arlen / i_awlen  in  8  beats minus 1.
- i_arsize / i_awsize  in  3  bytes per beat = 1<<size.
- i_arburst / i_awburst  in  2  burst type: 00 FIXED, 01 INCR, 10 WRAP, 11 treated as INCR.
- i_arlock/i_awlock (2), i_arcache/i_awcache (4), i_arprot/i_awprot (3), i_arqos/i_awqos (4), i_arregion/i_awregion (4), i_aruser/i_awuser/i_wuser (USER_WIDTH)  in  ignored sideband inputs.
- i_arvalid / o_arready, i_awvalid / o_awready  in/out  1  address handshakes.
- o_rid  out  ID_WIDTH  latched ARID.
- o_rdata  out  DATA_WIDTH  read data.
- o_rresp  out  2  always 00.
- o_rlast  out  1  final read beat.
- o_ruser  out  USER_WIDTH  always 0.
- o_rvalid / i_rready  out/in  1  read data handshake.
- i_wdata  in  DATA_WIDTH  write data.
- i_wstrb  in  DATA_WIDTH/8  byte enables.
- i_wlast  in  1  ignored; the slave counts beats itself.
- i_wvalid / o_wready  in/out  1  write data handshake.
- o_bid  out  ID_WIDTH  latched AWID.
- o_bresp  out  2  always 00.
- o_buser  out  USER_WIDTH  always 0.
- o_bvalid / i_bready  out/in  1  write response handshake.

Behaviour:
- Memory: 2^ADDR_WIDTH bytes. A beat at address A uses word index A>>3; byte lane L maps to byte (A & ~7)+L.
- Reset (async, any time, including mid-burst): both FSMs return to IDLE; memory byte k reloads k[7:0].
- Output reset values: o_arready=1, o_awready=1, all other outputs 0.
- Read FSM, IDLE -> RDATA:
  - In IDLE, o_arready=1. On arvalid&&arready, latch id, addr, len, size and burst; clear the beat counter; go to RDATA next cycle.
  - In RDATA, o_arready=0 and o_rvalid=1. o_rdata = full 64-bit word at the current address, combinational from the array.
  - o_rlast=1 when beat counter == len.
  - On rvalid&&rready: counter+1 and address advances. If it was the last beat, return to IDLE (rvalid=0 next cycle).
  - While rready=0, rdata, rlast and rvalid hold.
  - A read latency of one cycle from AR handshake to first rvalid is required.
- Write FSM, IDLE -> WDATA -> RESP:
  - In IDLE, o_awready=1. On the AW handshake, latch fields; go to WDATA.
  - In WDATA, o_wready=1. On wvalid&&wready, write each byte lane whose strb bit is 1 at the current word, then advance the address.
  - After beat index == len, go to RESP.
  - In RESP, o_bvalid=1, o_bresp=00, o_bid=latched id. On bready, go to IDLE.
  - In IDLE o_wready=0 (W data before AW is not accepted). o_awready=0 outside IDLE.
- Address advance (both channels):
  - FIXED: address unchanged.
  - INCR: address + (1<<size), modulo 2^ADDR_WIDTH (wraps at 0xFF->0x00).
  - WRAP: boundary = (len+1)<<size. Next = (A & ~(boundary-1)) | ((A+(1<<size)) & (boundary-1)). If len is not 1, 3, 7 or 15, WRAP behaves as INCR.
- Simultaneous read and write to the same word in one cycle: the read returns pre-write data; the write takes effect at the clock edge.
- Read and write channels operate concurrently and independently.

Test Plan:
- Reset, then AR addr=0x08, len=0, size=3, INCR, rready=1 -> one beat, rdata=0x0F0E0D0C0B0A0908, rlast=1, rid=1, rresp=0.
- AR addr=0x10, len=1, FIXED -> two beats, both 0x1716151413121110; rlast only on the 2nd; arready returns to 1 after.
- AW addr=0x00, len=8, size=3, INCR; W beats data=0x1111_0000_0000_0000+i, strb=0xFF -> 9 wready handshakes, then bvalid=1, bid=1, bresp=0. INCR readback len=8 returns the same 9 words.
- Write 0xFFFF_FFFF_FFFF_FFFF with strb=0x0F at 0x20, then read 0x20 -> 0x27262524FFFFFFFF.
- WRAP read addr=0x18, len=3, size=3 -> words from 0x18, 0x00, 0x08, 0x10, i.e. 0x1F1E1D1C1B1A1918, 0x0706050403020100, 0x0F0E0D0C0B0A0908, 0x1716151413121110.
- Backpressure, then reset:
  - Hold rready=0 for 3 cycles mid-burst -> rvalid/rdata stable.
  - Hold bready=0 -> bvalid held.
  - Assert reset mid-write -> all outputs return to reset values and memory reloads k[7:0].
